// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data memory / MMIO target: bus widths, load/store
// op encodings, timer register offsets and the timer register-select decode.
package dmem_mmio_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] MEM_OP_B  = 4'd0;
   localparam logic [3:0] MEM_OP_H  = 4'd1;
   localparam logic [3:0] MEM_OP_W  = 4'd2;
   localparam logic [3:0] MEM_OP_BU = 4'd4;
   localparam logic [3:0] MEM_OP_HU = 4'd5;

   localparam logic [15:0] MMIO_MSIP        = 16'h0000;
   localparam logic [15:0] MMIO_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] MMIO_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] MMIO_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] MMIO_MTIME_HI    = 16'hBFFC;

   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} access_size_e;

   typedef enum logic [2:0] {
      TSEL_NONE,
      TSEL_MSIP,
      TSEL_CMP_LO,
      TSEL_CMP_HI,
      TSEL_TIME_LO,
      TSEL_TIME_HI
   } timer_sel_e;

   // Registers are decoded per word so sub-word loads land inside the register.
   function automatic timer_sel_e timer_decode(input logic [13:0] word_offset);
      timer_sel_e sel;
      case (word_offset)
         MMIO_MSIP[15:2]:        sel = TSEL_MSIP;
         MMIO_MTIMECMP_LO[15:2]: sel = TSEL_CMP_LO;
         MMIO_MTIMECMP_HI[15:2]: sel = TSEL_CMP_HI;
         MMIO_MTIME_LO[15:2]:    sel = TSEL_TIME_LO;
         MMIO_MTIME_HI[15:2]:    sel = TSEL_TIME_HI;
         default:                sel = TSEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/dmem_timer.sv
// Machine timer block: prescaled 64-bit mtime, mtimecmp, msip, the mtime high
// shadow used for atomic 64-bit reads, and the registered timer interrupt.
module dmem_timer
   import dmem_mmio_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en,
   input  timer_sel_e  sel,
   input  logic [31:0] wdata,
   input  logic        shadow_latch,
   output logic [31:0] rdata,
   output logic        timer_irq,
   output logic        soft_irq
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;
   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic [63:0]   mtime_next;
   logic [63:0]   cmp_next;
   logic [31:0]   shadow;
   logic          msip;
   logic          tick;

   assign tick     = (pre_cnt == PW'(PRESCALE - 1));
   assign soft_irq = msip;

   // A software write to either mtime half takes priority over the increment.
   always_comb begin
      mtime_next = mtime;
      cmp_next   = mtimecmp;
      if (wr_en && sel == TSEL_TIME_LO) begin
         mtime_next = {mtime[63:32], wdata};
      end else if (wr_en && sel == TSEL_TIME_HI) begin
         mtime_next = {wdata, mtime[31:0]};
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
      if (wr_en && sel == TSEL_CMP_LO) begin
         cmp_next[31:0] = wdata;
      end
      if (wr_en && sel == TSEL_CMP_HI) begin
         cmp_next[63:32] = wdata;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pre_cnt   <= '0;
         mtime     <= '0;
         mtimecmp  <= '1;
         shadow    <= '0;
         msip      <= 1'b0;
         timer_irq <= 1'b0;
      end else begin
         pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
         mtime     <= mtime_next;
         mtimecmp  <= cmp_next;
         timer_irq <= (mtime_next >= cmp_next);
         if (wr_en && sel == TSEL_MSIP) begin
            msip <= wdata[0];
         end
         if (shadow_latch) begin
            shadow <= mtime[63:32];
         end
      end
   end

   always_comb begin
      case (sel)
         TSEL_MSIP:    rdata = {31'b0, msip};
         TSEL_CMP_LO:  rdata = mtimecmp[31:0];
         TSEL_CMP_HI:  rdata = mtimecmp[63:32];
         TSEL_TIME_LO: rdata = mtime[31:0];
         TSEL_TIME_HI: rdata = shadow;
         default:      rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory and MMIO target for the MEM stage: address decode, lane steering,
// load extension and the data RAM. Optional access-fault reporting: DMEM_ACCESS_FAULT_EN.
module dmem_mmio
   import dmem_mmio_pkg::*;
#(
   parameter int          RAM_AW    = 12,
   parameter int          PRESCALE  = 1,
   parameter logic [31:0] MMIO_BASE = 32'h0200_0000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ram_request_i,
   input  logic                  ram_we_i,
   input  logic [3:0]            ram_op_i,
   input  logic [ADDR_WIDTH-1:0] ram_addr_i,
   input  logic [DATA_WIDTH-1:0] ram_wdata_i,
   output logic [DATA_WIDTH-1:0] ram_rdata_o,
   output logic                  timer_irq_o,
   output logic                  soft_irq_o,
   output logic                  fault_o,
   output logic [ADDR_WIDTH-1:0] fault_addr_o
);

   localparam int DEPTH = 1 << RAM_AW;

   logic [31:0]       mem [DEPTH];
   logic [RAM_AW-1:0] widx;
   access_size_e      size;
   timer_sel_e        tsel;
   logic              op_valid, is_signed, is_ram, is_mmio, aligned;
   logic              access_ok, load_ok, store_ok;
   logic [3:0]        be;
   logic [31:0]       wword, rword, shifted, timer_rdata;

   always_comb begin
      size      = SIZE_W;
      op_valid  = 1'b1;
      is_signed = 1'b0;
      case (ram_op_i)
         MEM_OP_B:  begin size = SIZE_B; is_signed = 1'b1; end
         MEM_OP_H:  begin size = SIZE_H; is_signed = 1'b1; end
         MEM_OP_W:  size = SIZE_W;
         MEM_OP_BU: size = SIZE_B;
         MEM_OP_HU: size = SIZE_H;
         default:   op_valid = 1'b0;
      endcase
   end

   assign widx    = ram_addr_i[RAM_AW+1:2];
   assign is_ram  = (ram_addr_i[ADDR_WIDTH-1:RAM_AW+2] == '0);
   assign tsel    = (!is_ram && ram_addr_i[31:16] == MMIO_BASE[31:16])
                    ? timer_decode(ram_addr_i[15:2]) : TSEL_NONE;
   assign is_mmio = (tsel != TSEL_NONE);
   assign aligned = (size == SIZE_H) ? !ram_addr_i[0] :
                    (size == SIZE_W) ? (ram_addr_i[1:0] == 2'b00) : 1'b1;

   assign access_ok = op_valid && aligned && (is_ram || is_mmio);
   assign load_ok   = ram_request_i && !ram_we_i && access_ok;
   // MMIO registers only accept full-word stores.
   assign store_ok  = rst_i && ram_request_i && ram_we_i && access_ok
                      && (is_ram || size == SIZE_W);

   always_comb begin
      be    = 4'hF;
      wword = ram_wdata_i;
      case (size)
         SIZE_B: begin
            be    = 4'b0001 << ram_addr_i[1:0];
            wword = {4{ram_wdata_i[7:0]}};
         end
         SIZE_H: begin
            be    = ram_addr_i[1] ? 4'b1100 : 4'b0011;
            wword = {2{ram_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (store_ok && is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end

   dmem_timer #(
      .PRESCALE(PRESCALE)
   ) u_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en       (store_ok && is_mmio),
      .sel         (tsel),
      .wdata       (ram_wdata_i),
      .shadow_latch(load_ok && tsel == TSEL_TIME_LO),
      .rdata       (timer_rdata),
      .timer_irq   (timer_irq_o),
      .soft_irq    (soft_irq_o)
   );

   assign rword   = is_ram ? mem[widx] : (is_mmio ? timer_rdata : '0);
   assign shifted = rword >> {ram_addr_i[1:0], 3'b000};

   always_comb begin
      ram_rdata_o = '0;
      if (load_ok) begin
         case (size)
            SIZE_B:  ram_rdata_o = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_H:  ram_rdata_o = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: ram_rdata_o = rword;
         endcase
      end
   end

`ifdef DMEM_ACCESS_FAULT_EN
   logic bad_access;

   assign bad_access = ram_request_i && !(access_ok && (!ram_we_i || is_ram || size == SIZE_W));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fault_o      <= 1'b0;
         fault_addr_o <= '0;
      end else begin
         fault_o <= bad_access;
         if (bad_access) begin
            fault_addr_o <= ram_addr_i;
         end
      end
   end
`else
   assign fault_o      = 1'b0;
   assign fault_addr_o = '0;
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: byte-level memory/timer model compared every
// cycle, plus directed loads/stores with hand-computed expectations.
module tb_dmem_mmio;

   localparam logic [31:0] BASE     = 32'h0200_0000;
   localparam int          PRESCALE = 1;
   localparam int R_NONE = 0, R_RAM = 1, R_MSIP = 2, R_CMPLO = 3, R_CMPHI = 4, R_TLO = 5, R_THI = 6;
`ifdef DMEM_ACCESS_FAULT_EN
   localparam logic [31:0] EXP_FAULT = 32'd1;
   localparam logic [31:0] EXP_FADDR = 32'h101;
`else
   localparam logic [31:0] EXP_FAULT = 32'd0;
   localparam logic [31:0] EXP_FADDR = 32'd0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        ram_request_i = 1'b0;
   logic        ram_we_i = 1'b0;
   logic [3:0]  ram_op_i = 4'd2;
   logic [31:0] ram_addr_i = '0;
   logic [31:0] ram_wdata_i = '0;
   logic [31:0] ram_rdata_o;
   logic        timer_irq_o, soft_irq_o, fault_o;
   logic [31:0] fault_addr_o;

   int pass_count = 0;
   int total_count = 0;
   logic checking = 1'b0;

   logic [7:0]  m_mem [int];
   logic [63:0] m_time, m_cmp;
   logic [31:0] m_shadow, m_fault_addr;
   logic        m_msip, m_irq, m_fault;
   int          m_pre;

   dmem_mmio #(.RAM_AW(12), .PRESCALE(PRESCALE), .MMIO_BASE(BASE)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ram_request_i(ram_request_i), .ram_we_i(ram_we_i),
      .ram_op_i(ram_op_i), .ram_addr_i(ram_addr_i), .ram_wdata_i(ram_wdata_i),
      .ram_rdata_o(ram_rdata_o), .timer_irq_o(timer_irq_o), .soft_irq_o(soft_irq_o),
      .fault_o(fault_o), .fault_addr_o(fault_addr_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int op_size(input logic [3:0] op);
      case (op)
         4'd0, 4'd4: return 1;
         4'd1, 4'd5: return 2;
         4'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic int region(input logic [31:0] a);
      logic [31:0] off;
      if (a < 32'h4000) return R_RAM;
      if (a < BASE || (a - BASE) >= 32'h1_0000) return R_NONE;
      off = (a - BASE) & ~32'd3;
      case (off)
         32'h0000: return R_MSIP;
         32'h4000: return R_CMPLO;
         32'h4004: return R_CMPHI;
         32'hBFF8: return R_TLO;
         32'hBFFC: return R_THI;
         default:  return R_NONE;
      endcase
   endfunction

   function automatic logic [31:0] model_reg(input int rg);
      case (rg)
         R_MSIP:  return {31'b0, m_msip};
         R_CMPLO: return m_cmp[31:0];
         R_CMPHI: return m_cmp[63:32];
         R_TLO:   return m_time[31:0];
         R_THI:   return m_shadow;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ok_access(input int sz, input int rg);
      return sz != 0 && rg != R_NONE && (ram_addr_i % 32'(sz)) == 0;
   endfunction

   // Expected load data: gather bytes little-endian, then extend per op.
   function automatic logic [31:0] model_rdata();
      int sz, rg, a;
      logic [31:0] v;
      sz = op_size(ram_op_i);
      rg = region(ram_addr_i);
      if (!ram_request_i || ram_we_i || !ok_access(sz, rg)) return 32'd0;
      v = 32'd0;
      if (rg == R_RAM) begin
         for (int i = 0; i < sz; i++) begin
            a = int'(ram_addr_i) + i;
            if (m_mem.exists(a)) v = v | (32'(m_mem[a]) << (8 * i));
         end
      end else begin
         v = model_reg(rg) >> (8 * int'(ram_addr_i[1:0]));
         if (sz == 1) v = v & 32'hFF;
         if (sz == 2) v = v & 32'hFFFF;
      end
      if (ram_op_i == 4'd0) v = {{24{v[7]}}, v[7:0]};
      if (ram_op_i == 4'd1) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic model_step();
      int sz, rg;
      logic ok, wrote_time;
      logic [63:0] t;
      if (!rst_i) begin
         m_time = '0; m_cmp = '1; m_shadow = '0; m_msip = 1'b0; m_pre = 0;
         m_irq = 1'b0; m_fault = 1'b0; m_fault_addr = '0;
         return;
      end
      sz = op_size(ram_op_i);
      rg = region(ram_addr_i);
      ok = ram_request_i && ok_access(sz, rg);
      t = m_time;
      wrote_time = 1'b0;
      if (ok && ram_we_i) begin
         if (rg == R_RAM) begin
            for (int i = 0; i < sz; i++) m_mem[int'(ram_addr_i) + i] = ram_wdata_i[8*i +: 8];
         end else if (sz == 4) begin
            case (rg)
               R_MSIP:  m_msip = ram_wdata_i[0];
               R_CMPLO: m_cmp[31:0] = ram_wdata_i;
               R_CMPHI: m_cmp[63:32] = ram_wdata_i;
               R_TLO:   begin t[31:0] = ram_wdata_i; wrote_time = 1'b1; end
               R_THI:   begin t[63:32] = ram_wdata_i; wrote_time = 1'b1; end
               default: ;
            endcase
         end
      end
      if (ok && !ram_we_i && rg == R_TLO) m_shadow = m_time[63:32];
      m_pre = m_pre + 1;
      if (m_pre == PRESCALE) begin
         m_pre = 0;
         if (!wrote_time) t = t + 64'd1;
      end
      m_time = t;
      m_irq = (m_time >= m_cmp);
`ifdef DMEM_ACCESS_FAULT_EN
      m_fault = ram_request_i && !(ok && (!ram_we_i || rg == R_RAM || sz == 4));
      if (m_fault) m_fault_addr = ram_addr_i;
`else
      m_fault = 1'b0;
`endif
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   always @(negedge clk_i) begin
      if (checking) begin
         check_output("model_rdata", ram_rdata_o, model_rdata());
         check_output("model_timer_irq", {31'b0, timer_irq_o}, {31'b0, m_irq});
         check_output("model_soft_irq", {31'b0, soft_irq_o}, {31'b0, m_msip});
         check_output("model_fault", {31'b0, fault_o}, {31'b0, m_fault});
         check_output("model_fault_addr", fault_addr_o, m_fault_addr);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   task automatic apply_stimulus(input logic req, input logic we, input logic [3:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata);
      ram_request_i = req; ram_we_i = we; ram_op_i = op; ram_addr_i = addr; ram_wdata_i = wdata;
      @(negedge clk_i);
      #1;
   endtask

   task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      apply_stimulus(1'b1, 1'b1, op, addr, wdata);
      tick();
   endtask

   task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] exp, input string name);
      apply_stimulus(1'b1, 1'b0, op, addr, 32'd0);
      check_output(name, ram_rdata_o, exp);
      tick();
   endtask

   initial begin
      bit seen;
      tick();
      checking = 1'b1;
      tick();
      rst_i = 1'b1;

      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      check_output("reset_timer_irq", {31'b0, timer_irq_o}, 32'd0);
      check_output("reset_soft_irq", {31'b0, soft_irq_o}, 32'd0);
      check_output("reset_fault", {31'b0, fault_o}, 32'd0);
      tick();
      do_load(4'd2, BASE + 32'h4004, 32'hFFFF_FFFF, "reset_mtimecmp_hi");

      // RAM lanes and extension
      do_store(4'd2, 32'h100, 32'h8765_4321);
      do_load(4'd0, 32'h101, 32'h0000_0043, "lb_101");
      do_load(4'd0, 32'h103, 32'hFFFF_FF87, "lb_103");
      do_load(4'd5, 32'h102, 32'h0000_8765, "lhu_102");
      do_load(4'd1, 32'h102, 32'hFFFF_8765, "lh_102");
      do_load(4'd2, 32'h100, 32'h8765_4321, "lw_100");
      do_store(4'd2, 32'h104, 32'h0);
      do_store(4'd0, 32'h105, 32'h0000_00AA);
      do_load(4'd2, 32'h104, 32'h0000_AA00, "sb_lane_105");
      do_load(4'd1, 32'h101, 32'h0, "lh_misaligned");
      do_store(4'd1, 32'h101, 32'h0000_BEEF);
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      check_output("sh_misaligned_fault", {31'b0, fault_o}, EXP_FAULT);
      check_output("sh_misaligned_faddr", fault_addr_o, EXP_FADDR);
      tick();
      do_load(4'd2, 32'h100, 32'h8765_4321, "ram_unchanged");
      do_load(4'd2, 32'h0000_8000, 32'h0, "unmapped_ram_hole");
      do_load(4'd2, BASE + 32'h10, 32'h0, "unmapped_mmio");

      // Software interrupt register
      do_store(4'd2, BASE, 32'h1);
      do_load(4'd2, BASE, 32'h1, "msip_set");
      check_output("soft_irq_set", {31'b0, soft_irq_o}, 32'd1);
      do_store(4'd0, BASE, 32'h0);
      do_load(4'd2, BASE, 32'h1, "msip_sb_ignored");
      do_store(4'd2, BASE, 32'h0);
      do_load(4'd2, BASE, 32'h0, "msip_cleared");

      // Timer compare from a fresh reset: mtime counts 1,2,... after reset release
      rst_i = 1'b0;
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      tick();
      rst_i = 1'b1;
      do_store(4'd2, BASE + 32'h4004, 32'h0);
      do_store(4'd2, BASE + 32'h4000, 32'd20);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         apply_stimulus(1'b1, 1'b0, 4'd2, BASE + 32'hBFF8, 32'd0);
         if (timer_irq_o) begin
            seen = 1'b1;
            check_output("irq_rise_at_mtime", ram_rdata_o, 32'd20);
         end
         tick();
      end
      if (!seen) begin
         total_count++;
         $display("[TB] FAIL irq_rise_timeout: got no timer_irq_o, expected rise within 100 cycles");
      end
      do_store(4'd2, BASE + 32'h4000, 32'hFFFF_FFFF);
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      check_output("irq_drop", {31'b0, timer_irq_o}, 32'd0);
      tick();
      do_store(4'd2, BASE + 32'h4004, 32'hFFFF_FFFF);

      // mtime writes beat the increment; carry into the high half via shadow
      do_store(4'd2, BASE + 32'hBFF8, 32'hFFFF_FFFE);
      do_store(4'd2, BASE + 32'hBFFC, 32'h0);
      do_load(4'd2, BASE + 32'hBFF8, 32'hFFFF_FFFE, "mtime_write_wins");
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      tick();
      do_load(4'd2, BASE + 32'hBFF8, 32'h0, "mtime_lo_wrapped");
      do_load(4'd2, BASE + 32'hBFFC, 32'h1, "mtime_hi_shadow");

      // Reset while the compare condition holds
      do_store(4'd2, BASE + 32'h4004, 32'h0);
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      check_output("irq_before_reset", {31'b0, timer_irq_o}, 32'd1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      apply_stimulus(1'b1, 1'b0, 4'd2, BASE + 32'hBFF8, 32'd0);
      check_output("reset_mid_irq", {31'b0, timer_irq_o}, 32'd0);
      check_output("reset_mid_mtime", ram_rdata_o, 32'd0);
      check_output("reset_mid_fault", {31'b0, fault_o}, 32'd0);
      tick();
      do_load(4'd2, BASE + 32'h4000, 32'hFFFF_FFFF, "reset_mid_cmp_lo");
      apply_stimulus(1'b0, 1'b0, 4'd2, 32'd0, 32'd0);
      tick();

      checking = 1'b0;
      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
